// File: rtl/alu_share_arb.sv
// One combinational ALU shared by two valid/ready requesters. An IDLE/EXEC/RESP
// sequencer grants a port, runs its op for one cycle and holds the result.

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  aluc,
   output logic [31:0] r,
   output logic        zero,
   output logic        carry,
   output logic        negative,
   output logic        overflow
);

   logic [32:0]        sum;
   logic [32:0]        diff;
   logic [32:0]        shr;
   logic signed [32:0] sra;
   logic [32:0]        shl;
   logic [4:0]         sa;

   // Shifts carry one guard bit so the last bit shifted out lands in bit 0 / bit 32.
   // A shift amount of zero shifts nothing out, which leaves that guard bit at 0.
   assign sa   = a[4:0];
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign shr  = {b, 1'b0} >> sa;
   assign sra  = $signed({b, 1'b0}) >>> sa;
   assign shl  = {1'b0, b} << sa;

   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      r        = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (aluc)
         4'b0000: begin r = sum[31:0];  carry = sum[32];  end
         4'b0001: begin r = diff[31:0]; carry = diff[32]; end
         4'b0010: begin
            r        = sum[31:0];
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         4'b0011: begin
            r        = diff[31:0];
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = a ^ b;
         4'b0111: r = ~(a | b);
         4'b1000,
         4'b1001: r = {b[15:0], 16'h0000};
         // SUBU and SLTU report carry as the unsigned borrow, i.e. a < b.
         4'b1010: begin r = {31'd0, diff[32]}; carry = diff[32]; end
         4'b1011: r = {31'd0, $signed(a) < $signed(b)};
         4'b1100: begin r = sra[32:1]; carry = sra[0]; end
         4'b1101: begin r = shr[32:1]; carry = shr[0]; end
         default: begin r = shl[31:0]; carry = shl[32]; end
      endcase
   end

   assign zero     = (r == 32'd0);
   assign negative = r[31];

endmodule

module alu_share_arb #(
   parameter bit FAIR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid0,
   input  logic        req_valid1,
   output logic        req_ready0,
   output logic        req_ready1,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [3:0]  req_aluc0,
   input  logic [3:0]  req_aluc1,
   output logic        rsp_valid0,
   output logic        rsp_valid1,
   input  logic        rsp_ready0,
   input  logic        rsp_ready1,
   output logic [31:0] rsp_r,
   output logic [3:0]  flags0,
   output logic [3:0]  flags1,
   output logic        busy
);

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
      logic overflow;
   } flags_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state;
   logic        last_gnt;
   logic        gnt_id;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_aluc;
   flags_t      flags0_q;
   flags_t      flags1_q;

   logic        grant_any;
   logic        grant_sel;
   logic        accept;
   logic        upd_carry;
   logic        upd_ovf;
   flags_t      cur_flags;
   flags_t      new_flags;
   logic        rsp_hs;

   logic [31:0] alu_r;
   logic        alu_zero;
   logic        alu_carry;
   logic        alu_negative;
   logic        alu_overflow;

   always_comb begin
      grant_any = req_valid0 | req_valid1;
      if (req_valid0 && req_valid1)
         grant_sel = FAIR ? ~last_gnt : 1'b0;
      else
         grant_sel = ~req_valid0;
   end

   assign accept     = (state == S_IDLE) && grant_any && !rst;
   assign req_ready0 = accept && !grant_sel;
   assign req_ready1 = accept && grant_sel;

   alu u_alu (
      .a        (op_a),
      .b        (op_b),
      .aluc     (op_aluc),
      .r        (alu_r),
      .zero     (alu_zero),
      .carry    (alu_carry),
      .negative (alu_negative),
      .overflow (alu_overflow)
   );

   // The ALU's carry/overflow are meaningless for most codes, so they are masked here.
   always_comb begin
      upd_carry = 1'b0;
      upd_ovf   = 1'b0;
      case (op_aluc)
         4'b0000, 4'b0001, 4'b1010,
         4'b1100, 4'b1101, 4'b1110, 4'b1111: upd_carry = 1'b1;
         4'b0010, 4'b0011:                    upd_ovf   = 1'b1;
         default: ;
      endcase
      cur_flags          = gnt_id ? flags1_q : flags0_q;
      new_flags.zero     = alu_zero;
      new_flags.carry    = upd_carry ? alu_carry : cur_flags.carry;
      new_flags.negative = alu_negative;
      new_flags.overflow = upd_ovf ? alu_overflow : cur_flags.overflow;
   end

   assign rsp_hs = gnt_id ? rsp_ready1 : rsp_ready0;

   // NOTE: all state updates here are non-blocking so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         last_gnt <= 1'b1;
         gnt_id   <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_aluc  <= '0;
         rsp_r    <= '0;
         flags0_q <= '0;
         flags1_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  op_a     <= grant_sel ? req_a1 : req_a0;
                  op_b     <= grant_sel ? req_b1 : req_b0;
                  op_aluc  <= grant_sel ? req_aluc1 : req_aluc0;
                  gnt_id   <= grant_sel;
                  last_gnt <= grant_sel;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               rsp_r <= alu_r;
               if (gnt_id)
                  flags1_q <= new_flags;
               else
                  flags0_q <= new_flags;
               state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_hs)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid0 = (state == S_RESP) && !gnt_id;
   assign rsp_valid1 = (state == S_RESP) && gnt_id;
   assign flags0     = flags0_q;
   assign flags1     = flags1_q;
   assign busy       = (state != S_IDLE);

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer that shares one combinational `alu` instance between two requesters, such as a fetch-side address adder and an execute unit. Each requester presents an operation (a, b, aluc) over a valid/ready handshake. Each operation is granted round-robin or by fixed priority, applied to the shared ALU for one cycle, and returned through a held response. The block owns a per-port sticky flag register, so flag state is defined for every op code.

## Interface
- FAIR, 1, 1 = round-robin between ports, 0 = fixed priority (port 0 always wins)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid0 / req_valid1  in  1  port n presents an operation
- req_ready0 / req_ready1  out  1  single-cycle accept pulse to port n
- req_a0, req_b0 / req_a1, req_b1  in  32  operands for port n
- req_aluc0 / req_aluc1  in  4  op code for port n (alu encoding)
- rsp_valid0 / rsp_valid1  out  1  result for port n is available
- rsp_ready0 / rsp_ready1  in  1  port n consumes its result
- rsp_r  out  32  result of the last completed op (shared bus)
- flags0 / flags1  out  4  {zero, carry, negative, overflow} sticky flags of port n
- busy  out  1  high in every state except IDLE

## Operation
- FSM has three states: IDLE, EXEC, RESP. Only one operation is outstanding at any time.
- **IDLE**
  - If any req_valid is high, grant one port and pulse its req_ready for one cycle.
  - Latch a, b, aluc and the grant id into operand registers, then go to EXEC.
  - With no request, stay in IDLE.
- **Arbitration**
  - FAIR=1: on contention, grant the port not granted last. The last-grant pointer resets to "port 1 last", so port 0 wins the first tie.
  - FAIR=0: port 0 always wins.
  - A lone requester is always granted.
- **EXEC**
  - Operand registers drive the alu instance.
  - Capture the alu r output into rsp_r.
  - Update flags of the granted port only, using the mask below. Non-updated flags keep their prior values.
  - Go to RESP.
- **Flag update mask**
  - zero and negative are updated for all 16 codes.
  - carry is updated for 0000 ADDU, 0001 SUBU, 1010 SLTU, 1100 SRA, 1101 SRL, 1110/1111 SLL.
  - overflow is updated for 0010 ADD and 0011 SUB.
  - The controller must not sample alu carry/overflow outputs for other codes; those outputs are undefined for those codes.
- **RESP**
  - Assert rsp_validN for the granted port and hold it, with rsp_r stable, until rsp_readyN is high.
  - On that handshake, go to IDLE.
  - rsp_ready of the non-granted port is ignored.
- req_ready is never asserted outside IDLE. Requests arriving in EXEC/RESP wait with valid held high.
- Shift ops: a[4:0] is the shift amount and b is shifted. A shift amount of 0 gives carry=0.
- Widths: rsp_r is 32 bits; SLT/SLTU produce 0 or 1 zero-extended.

## Timing
- Reset values:
  - state IDLE, busy 0
  - req_ready0/1 = 0, rsp_valid0/1 = 0
  - rsp_r = 0, flags0 = flags1 = 4'b0000
  - last-grant pointer = port 1, operand registers = 0
- Accept occurs on edge N (req_ready high in the cycle before edge N). EXEC is the cycle after edge N. rsp_valid rises after edge N+1.
- Accept-to-response latency is 2 cycles. Minimum issue interval is 3 cycles when rsp_ready is held high.
- flagsN changes exactly at the EXEC→RESP edge and is visible in the same cycle rsp_validN first rises.
- If req_valid drops in the same cycle req_ready pulses, the op is still taken, because the handshake is sampled at the edge where both are high.
- Reset asserted in any state clears the operation. No response is produced and flags return to 0 on the next edge.

## Test plan
- **ADDU wrap:** port 0 sends a=0xFFFFFFFF, b=1, aluc=0000 -> rsp_valid0 two cycles after accept, rsp_r=0, flags0={1,1,0,0}.
- **ADD overflow with carry retained:** port 0 runs ADDU 0xFFFFFFFF+1, then ADD a=0x7FFFFFFF, b=1 (0010) -> rsp_r=0x80000000, flags0={0,1,1,1}. Carry stays 1 from the prior op.
- **Round-robin contention:** FAIR=1, both ports valid continuously with rsp_ready high -> grants alternate 0,1,0,1. With FAIR=0 -> all grants go to port 0 and port 1 waits.
- **Response backpressure:** port 1 SLL a=1, b=0x80000000 (1110) with rsp_ready1 held low for 5 cycles -> rsp_valid1 and rsp_r=0 stay stable, flags1={1,1,0,0}, busy=1, port 0 not granted until the handshake completes.
- **Per-port flag isolation:** port 1 SUB a=0, b=0 -> flags1 zero=1. flags0 is unchanged from its prior value.
- **Reset mid-op:** assert rst during EXEC -> next cycle IDLE, rsp_valid0/1=0, rsp_r=0, flags0/1=0. First contention after reset grants port 0.
